// File: rtl/load_store_unit_pkg.sv
// Shared load/store definitions: op and state encodings plus lane helpers.
// Imported by the LSU and by CPU-side logic that issues requests.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Width of the byte-lane index inside one bus word.
    function automatic int unsigned lane_sel_w(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic size_e op_size(input op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_B;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            default:              return SZ_W;
        endcase
    endfunction

    function automatic logic op_is_store(input op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response channel of the load/store unit.
interface load_store_unit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RD_W   = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [RD_W-1:0]   req_rd;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic [RD_W-1:0]   resp_rd;
    logic              resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_rd,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_rd,
        output req_ready, resp_valid, resp_data, resp_rd, resp_err
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byte enables, store replication, load extraction
// with sign/zero extension, and alignment check.
module lsu_lane_align
    import load_store_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  op_e                             op,
    input  logic [lane_sel_w(DATA_W)-1:0]   lane,
    input  logic [DATA_W-1:0]               wdata,
    input  logic [DATA_W-1:0]               rdata,
    output logic [DATA_W/8-1:0]             be_c,
    output logic [DATA_W-1:0]               wdata_c,
    output logic [DATA_W-1:0]               rdata_c,
    output logic                            misalign_c
);
    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned LANE_W = lane_sel_w(DATA_W);

    size_e             sz;
    logic [LANE_W-1:0] lane_h;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;

    always_comb begin
        sz         = op_size(op);
        lane_h     = lane & ~LANE_W'(1);
        byte_v     = 8'(rdata >> {lane, 3'b000});
        half_v     = 16'(rdata >> {lane_h, 3'b000});
        be_c       = '1;
        wdata_c    = wdata;
        rdata_c    = rdata;
        misalign_c = 1'b0;
        case (sz)
            SZ_B: begin
                be_c    = NB'(1) << lane;
                wdata_c = {NB{wdata[7:0]}};
                rdata_c = (op == OP_LB) ? DATA_W'($signed(byte_v)) : DATA_W'(byte_v);
            end
            SZ_H: begin
                be_c       = NB'(3) << lane_h;
                wdata_c    = {(NB/2){wdata[15:0]}};
                rdata_c    = (op == OP_LH) ? DATA_W'($signed(half_v)) : DATA_W'(half_v);
                misalign_c = lane[0];
            end
            default: begin
                misalign_c = |lane;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one CPU request, runs one
// memory access with timeout, and returns a one-cycle response.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned RD_W    = 3,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                                   clk,
    input  logic                                   rst,
    load_store_unit_if.slave                       cpu,
    output logic                                   mem_req,
    output logic                                   mem_we,
    output logic [ADDR_W-lane_sel_w(DATA_W)-1:0]   mem_addr,
    output logic [DATA_W/8-1:0]                    mem_be,
    output logic [DATA_W-1:0]                      mem_wdata,
    input  logic [DATA_W-1:0]                      mem_rdata,
    input  logic                                   mem_ack
);
    localparam int unsigned NB      = DATA_W / 8;
    localparam int unsigned LANE_W  = lane_sel_w(DATA_W);
    localparam int unsigned MADDR_W = ADDR_W - LANE_W;
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    op_e                 op_q, op_d, sel_op;
    logic [LANE_W-1:0]   lane_q, lane_d, sel_lane;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_req_d, mem_we_d;
    logic [MADDR_W-1:0]  mem_addr_d;
    logic [NB-1:0]       mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic [RD_W-1:0]     resp_rd_q, resp_rd_d;
    logic                resp_err_q, resp_err_d;
    logic [NB-1:0]       be_c;
    logic [DATA_W-1:0]   wdata_c, rdata_c;
    logic                misalign_c;

    assign cpu.req_ready  = req_ready_q;
    assign cpu.resp_valid = resp_valid_q;
    assign cpu.resp_data  = resp_data_q;
    assign cpu.resp_rd    = resp_rd_q;
    assign cpu.resp_err   = resp_err_q;

    // Aligner sees the incoming request while idle, the latched one afterwards.
    always_comb begin
        sel_op   = (state_q == ST_IDLE) ? op_e'(cpu.req_op) : op_q;
        sel_lane = (state_q == ST_IDLE) ? cpu.req_addr[LANE_W-1:0] : lane_q;
    end

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .op         (sel_op),
        .lane       (sel_lane),
        .wdata      (cpu.req_wdata),
        .rdata      (mem_rdata),
        .be_c       (be_c),
        .wdata_c    (wdata_c),
        .rdata_c    (rdata_c),
        .misalign_c (misalign_c)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_be_d    = mem_be;
        mem_wdata_d = mem_wdata;
        resp_data_d = resp_data_q;
        resp_rd_d   = resp_rd_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu.req_valid) begin
                    op_d      = sel_op;
                    lane_d    = sel_lane;
                    resp_rd_d = cpu.req_rd;
                    cnt_d     = CNT_W'(1);
                    if (misalign_c) begin
                        state_d     = ST_RESP;
                        resp_err_d  = 1'b1;
                        resp_data_d = '0;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = op_is_store(sel_op);
                        mem_addr_d  = cpu.req_addr[ADDR_W-1:LANE_W];
                        mem_be_d    = be_c;
                        mem_wdata_d = wdata_c;
                    end
                end
            end
            ST_ACCESS: begin
                // An ack in the final counted cycle still wins over the timeout.
                if (mem_ack) begin
                    state_d     = ST_RESP;
                    mem_req_d   = 1'b0;
                    resp_err_d  = 1'b0;
                    resp_data_d = op_is_store(op_q) ? '0 : rdata_c;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d     = ST_RESP;
                    mem_req_d   = 1'b0;
                    resp_err_d  = 1'b1;
                    resp_data_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        resp_valid_d = (state_d == ST_RESP);
        req_ready_d  = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_LB;
            lane_q       <= '0;
            cnt_q        <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            cnt_q        <= cnt_d;
            mem_req      <= mem_req_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_be       <= mem_be_d;
            mem_wdata    <= mem_wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected memory
// and response items; one negedge monitor plays memory and checks everything.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned RW = 3;
    localparam int unsigned TO = 4;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;
        int          cycles;
    } mem_t;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  rd;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we;
    logic [13:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack   = 1'b0;
    logic        chk_rst   = 1'b1;
    logic        end_chk   = 1'b0;

    mem_t  mq[$];
    resp_t rq[$];
    mem_t  cur;
    resp_t r;
    int    wcnt  = 0;
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit_if #(.DATA_W(DW), .ADDR_W(AW), .RD_W(RW)) cpu ();

    load_store_unit #(.DATA_W(DW), .ADDR_W(AW), .RD_W(RW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cpu),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic mem_t mk(input logic we, input logic [3:0] be, input logic [13:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int ack_dly, input int cycles);
        mem_t m;
        m.we = we; m.be = be; m.addr = addr; m.wdata = wdata;
        m.rdata = rdata; m.ack_dly = ack_dly; m.cycles = cycles;
        return m;
    endfunction

    // Memory model and all checks live in this single process.
    always @(negedge clk) begin
        if (chk_rst) begin
            chk("rst_req_ready", 64'(cpu.req_ready), 64'd1);
            chk("rst_ctrl", 64'({cpu.resp_valid, cpu.resp_err, cpu.resp_rd, mem_req, mem_we, mem_be, mem_addr}), 64'd0);
            chk("rst_data", {cpu.resp_data, mem_wdata}, 64'd0);
        end
        if (mem_req) begin
            if (wcnt == 0) begin
                chk("mem_req_expected", 64'(mq.size() > 0), 64'd1);
                if (mq.size() > 0) begin
                    cur = mq.pop_front();
                    chk("mem_we", 64'(mem_we), 64'(cur.we));
                    chk("mem_be", 64'(mem_be), 64'(cur.be));
                    chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
                    chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
                end else begin
                    cur = mk(1'b0, 4'h0, 14'h0, 32'h0, 32'h0, 0, 0);
                end
            end else begin
                chk("mem_stable", 64'({mem_we, mem_be, mem_addr, mem_wdata}),
                    64'({cur.we, cur.be, cur.addr, cur.wdata}));
            end
            wcnt      = wcnt + 1;
            mem_ack   = (cur.ack_dly != 0) && (wcnt == cur.ack_dly);
            mem_rdata = cur.rdata;
        end else begin
            if (wcnt != 0 && cur.cycles != 0)
                chk("mem_req_cycles", 64'(wcnt), 64'(cur.cycles));
            wcnt    = 0;
            mem_ack = 1'b0;
        end
        if (cpu.resp_valid) begin
            chk("resp_expected", 64'(rq.size() > 0), 64'd1);
            if (rq.size() > 0) begin
                r = rq.pop_front();
                chk("resp_data", 64'(cpu.resp_data), 64'(r.data));
                chk("resp_rd", 64'(cpu.resp_rd), 64'(r.rd));
                chk("resp_err", 64'(cpu.resp_err), 64'(r.err));
            end
        end
        if (end_chk)
            chk("pending_items", 64'(rq.size() + mq.size()), 64'd0);
    end

    task automatic send(input op_e op, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [2:0] rd, input bit has_mem, input mem_t m,
                        input bit has_resp, input logic [31:0] edata, input logic eerr);
        resp_t e;
        for (int i = 0; i < 20 && !cpu.req_ready; i++) begin
            @(posedge clk); #2;
        end
        if (has_mem) mq.push_back(m);
        if (has_resp) begin
            e.data = edata; e.rd = rd; e.err = eerr;
            rq.push_back(e);
        end
        cpu.req_valid = 1'b1;
        cpu.req_op    = 3'(op);
        cpu.req_addr  = addr;
        cpu.req_wdata = wdata;
        cpu.req_rd    = rd;
        @(posedge clk); #2;
        cpu.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && !cpu.req_ready; i++) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic issue(input op_e op, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [2:0] rd, input bit has_mem, input mem_t m,
                         input logic [31:0] edata, input logic eerr);
        send(op, addr, wdata, rd, has_mem, m, 1'b1, edata, eerr);
        wait_idle();
    endtask

    initial begin
        mem_t none;
        none = mk(1'b0, 4'h0, 14'h0, 32'h0, 32'h0, 0, 0);
        rst = 1'b0;
        cpu.req_valid = 1'b0; cpu.req_op = '0; cpu.req_addr = '0;
        cpu.req_wdata = '0;   cpu.req_rd = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0; chk_rst = 1'b0;

        issue(OP_LW,  16'h0010, 32'h0,        3'd5, 1, mk(0, 4'hF, 14'h0004, 32'h0,        32'hDEADBEEF, 2, 2), 32'hDEADBEEF, 0);
        issue(OP_LB,  16'h0013, 32'h0,        3'd1, 1, mk(0, 4'h8, 14'h0004, 32'h0,        32'h80FF0000, 1, 1), 32'hFFFFFF80, 0);
        issue(OP_LBU, 16'h0013, 32'h0,        3'd2, 1, mk(0, 4'h8, 14'h0004, 32'h0,        32'h80FF0000, 3, 3), 32'h00000080, 0);
        issue(OP_SH,  16'h0006, 32'h1234ABCD, 3'd3, 1, mk(1, 4'hC, 14'h0001, 32'hABCDABCD, 32'h0,        1, 1), 32'h0,        0);
        issue(OP_LW,  16'h0002, 32'h0,        3'd4, 0, none,                                                  32'h0,        1);
        issue(OP_LH,  16'h0003, 32'h0,        3'd6, 0, none,                                                  32'h0,        1);
        issue(OP_LH,  16'h0002, 32'h0,        3'd7, 1, mk(0, 4'hC, 14'h0000, 32'h0,        32'h80017FFF, 1, 1), 32'hFFFF8001, 0);
        issue(OP_LHU, 16'h0000, 32'h0,        3'd0, 1, mk(0, 4'h3, 14'h0000, 32'h0,        32'h1234F00D, 2, 2), 32'h0000F00D, 0);
        issue(OP_SB,  16'h0021, 32'h000000A5, 3'd1, 1, mk(1, 4'h2, 14'h0008, 32'hA5A5A5A5, 32'h0,        2, 2), 32'h0,        0);
        issue(OP_SW,  16'h00FC, 32'hCAFEF00D, 3'd2, 1, mk(1, 4'hF, 14'h003F, 32'hCAFEF00D, 32'h0,        1, 1), 32'h0,        0);
        // No ack: mem_req held for exactly TO cycles, then error.
        issue(OP_LW,  16'h0040, 32'h0,        3'd3, 1, mk(0, 4'hF, 14'h0010, 32'h0,        32'h55555555, 0, TO), 32'h0,      1);
        // Ack in the cycle the counter reaches TO still succeeds.
        issue(OP_LW,  16'h0044, 32'h0,        3'd4, 1, mk(0, 4'hF, 14'h0011, 32'h0,        32'h11223344, TO, TO), 32'h11223344, 0);
        issue(OP_SW,  16'h0001, 32'h12345678, 3'd5, 0, none,                                                  32'h0,        1);
        issue(OP_LB,  16'h0001, 32'h0,        3'd6, 1, mk(0, 4'h2, 14'h0000, 32'h0,        32'h00007F00, 1, 1), 32'h0000007F, 0);

        // Reset in the second access cycle: mem_req must drop before the next edge, no response.
        send(OP_LW, 16'h0080, 32'h0, 3'd7, 1, mk(0, 4'hF, 14'h0020, 32'h0, 32'h0, 0, 0), 0, 32'h0, 0);
        @(posedge clk); #2;
        rst = 1'b1; chk_rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0; chk_rst = 1'b0;

        issue(OP_LBU, 16'h0001, 32'h0,        3'd2, 1, mk(0, 4'h2, 14'h0000, 32'h0,        32'h00008000, 1, 1), 32'h00000080, 0);

        repeat (3) @(posedge clk);
        #2 end_chk = 1'b1;
        @(posedge clk); #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
